disp_arbiter: RTL and testbench

- Owns the single 8-digit seven-segment display and decides each cycle which producer drives it: clock, calendar, alarm-setting or countdown datapath.
- Steps the user-selected view on the mode key.
- Pre-empts the view for alarm-ring and countdown-expiry events.
- Overlays a blink mask on the field under edit.
- Sits between the time/calendar counters and the hex8 display driver.

---
 rtl/disp_pkg.sv | 33 +++
 rtl/blink_gen.sv | 43 ++++
 rtl/disp_arbiter.sv | 164 ++++++++++++++++
 tb/tb_disp_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared display constants, source/state encodings and edit-field masks
// for the display arbiter.
package disp_pkg;

  localparam logic [3:0] DIGIT_BLANK = 4'hF;
  localparam logic [3:0] DIGIT_POINT = 4'hA;

  typedef enum logic [1:0] {
    SRC_CLOCK     = 2'd0,
    SRC_CALENDAR  = 2'd1,
    SRC_ALARM     = 2'd2,
    SRC_COUNTDOWN = 2'd3
  } disp_src_e;

  typedef enum logic [1:0] {
    VIEW  = 2'd0,
    ALARM = 2'd1,
    CDONE = 2'd2
  } arb_state_e;

  // Bits of the 32-bit image that belong to each editable field.
  function automatic logic [31:0] field_mask(input logic [1:0] field);
    logic [31:0] m;
    case (field)
      2'd0:    m = 32'hFF00_0000;
      2'd1:    m = 32'h000F_F000;
      2'd2:    m = 32'h0000_00FF;
      default: m = 32'h0000_0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/blink_gen.sv
// Blink phase generator: free-running 0..MCNT counter, phase toggles on wrap;
// restart forces count 0 and phase on so the flashed field shows at once.
module blink_gen #(
  parameter int unsigned MCNT = 3
) (
  input  logic Clk,
  input  logic Reset,
  input  logic restart_i,
  output logic phase_next_o
);

  localparam int W = (MCNT > 0) ? $clog2(MCNT + 1) : 1;
  localparam logic [W-1:0] CNT_MAX = W'(MCNT);

  logic [W-1:0] cnt_q, cnt_d;
  logic         phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    phase_d = phase_q;
    if (restart_i) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  // Outputs downstream are registered from next-state, so hand out phase_d.
  assign phase_next_o = phase_d;

endmodule

// File: rtl/disp_arbiter.sv
// Display owner: picks clock/calendar/alarm/countdown image, pre-empts on events.
// VIEW: user-selected view | ALARM: alarm ring, clock flashing | CDONE: countdown expiry flashing
module disp_arbiter
  import disp_pkg::*;
#(
  parameter int unsigned MCNT_BLINK   = 25_000_000 - 1,
  parameter int unsigned ALARM_SHOW_S = 60
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Mode_key,
  input  logic        Ack_key,
  input  logic        Sec_tick,
  input  logic [31:0] Clock_data,
  input  logic [31:0] Calendar_data,
  input  logic [31:0] Alarm_data,
  input  logic [31:0] Countdown_data,
  input  logic        Alarm_req,
  input  logic        Countdown_done,
  input  logic        Edit_en,
  input  logic [1:0]  Edit_field,
  output logic [31:0] Disp_data,
  output logic [1:0]  Disp_src,
  output logic        Event_active,
  output logic        Buzzer_en
);

  localparam logic [5:0]  SHOW_S    = 6'(ALARM_SHOW_S);
  localparam logic [31:0] ALL_BLANK = {8{DIGIT_BLANK}};

  arb_state_e  state_q, state_d;
  logic [1:0]  view_q, view_d;
  logic [5:0]  sec_cnt_q, sec_cnt_d;
  logic        alarm_req_q, edit_en_q;
  logic [1:0]  edit_field_q;
  logic        alarm_rise, timeout, entry, restart, phase_d;

  logic [31:0] disp_data_q, disp_data_d, view_image, mask;
  logic [1:0]  disp_src_q, disp_src_d;
  logic        event_q, event_d, buzzer_q, buzzer_d;

  assign alarm_rise = Alarm_req & ~alarm_req_q;
  assign timeout    = (sec_cnt_q == SHOW_S);

  always_comb begin
    state_d = state_q;
    view_d  = view_q;
    entry   = 1'b0;
    case (state_q)
      VIEW: begin
        if (alarm_rise) begin
          state_d = ALARM;
          entry   = 1'b1;
        end else if (Countdown_done) begin
          state_d = CDONE;
          entry   = 1'b1;
        end else if (Mode_key) begin
          view_d = view_q + 2'd1;
        end
      end
      ALARM, CDONE: begin
        // A fresh alarm edge always (re)enters ALARM and outranks dismissal.
        if (alarm_rise) begin
          state_d = ALARM;
          entry   = 1'b1;
        end else if (Ack_key || timeout) begin
          state_d = VIEW;
          entry   = 1'b1;
        end
      end
      default: begin
        state_d = VIEW;
        entry   = 1'b1;
      end
    endcase
  end

  always_comb begin
    sec_cnt_d = sec_cnt_q;
    if (entry)
      sec_cnt_d = '0;
    else if (state_q != VIEW && Sec_tick)
      sec_cnt_d = sec_cnt_q + 6'd1;
  end

  assign restart = entry | (Edit_field != edit_field_q) | (Edit_en & ~edit_en_q);

  blink_gen #(
    .MCNT (MCNT_BLINK)
  ) u_blink (
    .Clk          (Clk),
    .Reset        (Reset),
    .restart_i    (restart),
    .phase_next_o (phase_d)
  );

  always_comb begin
    case (view_d)
      SRC_CLOCK:    view_image = Clock_data;
      SRC_CALENDAR: view_image = Calendar_data;
      SRC_ALARM:    view_image = Alarm_data;
      default:      view_image = Countdown_data;
    endcase
  end

  assign mask = field_mask(Edit_field);

  always_comb begin
    disp_src_d  = view_d;
    disp_data_d = view_image;
    event_d     = 1'b0;
    buzzer_d    = 1'b0;
    case (state_d)
      ALARM: begin
        disp_src_d  = SRC_CLOCK;
        disp_data_d = phase_d ? Clock_data : ALL_BLANK;
        event_d     = 1'b1;
        buzzer_d    = phase_d;
      end
      CDONE: begin
        disp_src_d  = SRC_COUNTDOWN;
        disp_data_d = phase_d ? Countdown_data : ALL_BLANK;
        event_d     = 1'b1;
        buzzer_d    = phase_d;
      end
      default: begin
        if (Edit_en && Edit_field != 2'd3 && !phase_d)
          disp_data_d = (view_image & ~mask) | (ALL_BLANK & mask);
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= VIEW;
      view_q       <= 2'd0;
      sec_cnt_q    <= '0;
      alarm_req_q  <= 1'b0;
      edit_en_q    <= 1'b0;
      edit_field_q <= 2'd0;
      disp_data_q  <= '0;
      disp_src_q   <= 2'd0;
      event_q      <= 1'b0;
      buzzer_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      view_q       <= view_d;
      sec_cnt_q    <= sec_cnt_d;
      alarm_req_q  <= Alarm_req;
      edit_en_q    <= Edit_en;
      edit_field_q <= Edit_field;
      disp_data_q  <= disp_data_d;
      disp_src_q   <= disp_src_d;
      event_q      <= event_d;
      buzzer_q     <= buzzer_d;
    end
  end

  assign Disp_data    = disp_data_q;
  assign Disp_src     = disp_src_q;
  assign Event_active = event_q;
  assign Buzzer_en    = buzzer_q;

endmodule

// File: tb/tb_disp_arbiter.sv
// Self-checking bench for disp_arbiter: directed scenarios then random
// stimulus, all compared cycle by cycle against a behavioural model.
module tb_disp_arbiter;

  localparam int BLINK_MAX = 3;
  localparam int SHOW_S    = 3;

  logic        Clk = 1'b0;
  logic        Reset, Mode_key, Ack_key, Sec_tick;
  logic [31:0] Clock_data, Calendar_data, Alarm_data, Countdown_data;
  logic        Alarm_req, Countdown_done, Edit_en;
  logic [1:0]  Edit_field;
  logic [31:0] Disp_data;
  logic [1:0]  Disp_src;
  logic        Event_active, Buzzer_en;

  int n_checks = 0;
  int n_errors = 0;

  always #5 Clk = ~Clk;

  disp_arbiter #(
    .MCNT_BLINK   (BLINK_MAX),
    .ALARM_SHOW_S (SHOW_S)
  ) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .Mode_key       (Mode_key),
    .Ack_key        (Ack_key),
    .Sec_tick       (Sec_tick),
    .Clock_data     (Clock_data),
    .Calendar_data  (Calendar_data),
    .Alarm_data     (Alarm_data),
    .Countdown_data (Countdown_data),
    .Alarm_req      (Alarm_req),
    .Countdown_done (Countdown_done),
    .Edit_en        (Edit_en),
    .Edit_field     (Edit_field),
    .Disp_data      (Disp_data),
    .Disp_src       (Disp_src),
    .Event_active   (Event_active),
    .Buzzer_en      (Buzzer_en)
  );

  // Reference model: event kind 0 none, 1 alarm, 2 countdown.
  int          m_event, m_view, m_secs, m_bcnt, m_field_prev;
  bit          m_phase, m_alarm_prev, m_en_prev;
  logic [31:0] exp_data;
  logic [1:0]  exp_src;
  logic        exp_event, exp_buzz;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [31:0] blank_field(input logic [31:0] d, input int f);
    logic [31:0] r;
    int hi;
    r  = d;
    hi = (f == 0) ? 7 : (f == 1) ? 4 : 1;
    r[hi*4 +: 4]     = 4'hF;
    r[(hi-1)*4 +: 4] = 4'hF;
    return r;
  endfunction

  function automatic logic [31:0] source_image(input int v);
    case (v)
      0:       return Clock_data;
      1:       return Calendar_data;
      2:       return Alarm_data;
      default: return Countdown_data;
    endcase
  endfunction

  task automatic model_step();
    bit rise, restart;
    if (Reset) begin
      m_event = 0; m_view = 0; m_secs = 0; m_bcnt = 0; m_phase = 1;
      m_alarm_prev = 0; m_en_prev = 0; m_field_prev = 0;
      exp_data = 0; exp_src = 0; exp_event = 0; exp_buzz = 0;
      return;
    end
    rise    = Alarm_req && !m_alarm_prev;
    restart = 0;
    if (m_event != 0) begin
      if (rise) begin
        m_event = 1; m_secs = 0; restart = 1;
      end else if (Ack_key || m_secs == SHOW_S) begin
        m_event = 0; m_secs = 0; restart = 1;
      end else if (Sec_tick) begin
        m_secs = (m_secs + 1) % 64;
      end
    end else begin
      if (rise) begin
        m_event = 1; m_secs = 0; restart = 1;
      end else if (Countdown_done) begin
        m_event = 2; m_secs = 0; restart = 1;
      end else if (Mode_key) begin
        m_view = (m_view + 1) % 4;
      end
    end
    if (int'(Edit_field) != m_field_prev || (Edit_en && !m_en_prev)) restart = 1;
    if (restart) begin
      m_bcnt = 0; m_phase = 1;
    end else if (m_bcnt == BLINK_MAX) begin
      m_bcnt = 0; m_phase = !m_phase;
    end else begin
      m_bcnt++;
    end
    m_alarm_prev = Alarm_req;
    m_en_prev    = Edit_en;
    m_field_prev = int'(Edit_field);

    exp_event = (m_event != 0);
    exp_buzz  = (m_event != 0) && m_phase;
    if (m_event == 1) begin
      exp_src  = 2'd0;
      exp_data = m_phase ? Clock_data : 32'hFFFF_FFFF;
    end else if (m_event == 2) begin
      exp_src  = 2'd3;
      exp_data = m_phase ? Countdown_data : 32'hFFFF_FFFF;
    end else begin
      exp_src  = 2'(m_view);
      exp_data = source_image(m_view);
      if (Edit_en && Edit_field != 2'd3 && !m_phase)
        exp_data = blank_field(exp_data, int'(Edit_field));
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      model_step();
      #1;
      check_val("disp_data", Disp_data, exp_data);
      check_val("disp_src", 32'(Disp_src), 32'(exp_src));
      check_val("event_active", 32'(Event_active), 32'(exp_event));
      check_val("buzzer_en", 32'(Buzzer_en), 32'(exp_buzz));
    end
  endtask

  task automatic pulse_tick(input int gap);
    Sec_tick = 1; step(1); Sec_tick = 0; step(gap);
  endtask

  initial begin
    logic [1:0] src_seq [4];
    src_seq = '{2'd1, 2'd2, 2'd3, 2'd0};

    Reset = 1; Mode_key = 0; Ack_key = 0; Sec_tick = 0;
    Alarm_req = 0; Countdown_done = 0; Edit_en = 0; Edit_field = 2'd0;
    Clock_data     = 32'h12A34A56;
    Calendar_data  = 32'h25A09A04;
    Alarm_data     = 32'h00A30A07;
    Countdown_data = 32'h00A00A00;
    #2;

    // Reset and view stepping
    step(2);
    check_val("rst_data", Disp_data, 32'h0);
    Reset = 0;
    step(1);
    check_val("view0_data", Disp_data, 32'h12A34A56);
    for (int k = 0; k < 4; k++) begin
      Mode_key = 1; step(1); Mode_key = 0;
      check_val("mode_src", 32'(Disp_src), 32'(src_seq[k]));
      step(2);
    end

    // Edit overlay on field 1 of the clock view
    Edit_en = 1; Edit_field = 2'd1;
    step(1);
    check_val("edit_visible", Disp_data, 32'h12A34A56);
    step(4);
    check_val("edit_blank", Disp_data, 32'h12AFFA56);
    step(11);
    Edit_en = 0; Edit_field = 2'd3;
    step(2);

    // Alarm in view 2, timeout after three seconds
    Mode_key = 1; step(1); Mode_key = 0; step(1);
    Mode_key = 1; step(1); Mode_key = 0; step(1);
    Alarm_req = 1; step(1);
    check_val("alarm_event", 32'(Event_active), 32'd1);
    check_val("alarm_src", 32'(Disp_src), 32'd0);
    step(5);
    pulse_tick(2); pulse_tick(2); pulse_tick(2);
    check_val("timeout_src", 32'(Disp_src), 32'd2);
    check_val("timeout_buzz", 32'(Buzzer_en), 32'd0);
    Alarm_req = 0; step(2);

    // Simultaneous alarm edge and countdown expiry, then ack; no re-trigger
    Alarm_req = 1; Countdown_done = 1; step(1); Countdown_done = 0;
    check_val("prio_src", 32'(Disp_src), 32'd0);
    step(3);
    Ack_key = 1; step(1); Ack_key = 0;
    step(5);
    check_val("no_retrigger", 32'(Event_active), 32'd0);
    Alarm_req = 0; step(2);

    // Countdown expiry, alarm edge restarts the seconds, mode key ignored
    Countdown_done = 1; step(1); Countdown_done = 0;
    check_val("cdone_src", 32'(Disp_src), 32'd3);
    step(2);
    pulse_tick(1);
    Alarm_req = 1; step(1);
    check_val("cd_to_alarm", 32'(Disp_src), 32'd0);
    Mode_key = 1; step(1); Mode_key = 0;
    pulse_tick(1); pulse_tick(2);
    check_val("restart_secs", 32'(Event_active), 32'd1);
    Ack_key = 1; step(1); Ack_key = 0;
    check_val("view_kept", 32'(Disp_src), 32'd2);
    Alarm_req = 0; step(2);

    // Reset mid-alarm
    Alarm_req = 1; step(3);
    Reset = 1; step(1);
    check_val("rst_mid_event", 32'(Event_active), 32'd0);
    check_val("rst_mid_buzz", 32'(Buzzer_en), 32'd0);
    Reset = 0; Alarm_req = 0; step(2);

    // Randomized stimulus
    for (int c = 0; c < 4000; c++) begin
      Reset          = ($urandom_range(0, 399) == 0);
      Mode_key       = ($urandom_range(0, 5) == 0);
      Ack_key        = ($urandom_range(0, 19) == 0);
      Sec_tick       = ($urandom_range(0, 3) == 0);
      Countdown_done = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 14) == 0) Alarm_req = ~Alarm_req;
      if ($urandom_range(0, 19) == 0) Edit_en = ~Edit_en;
      if ($urandom_range(0, 29) == 0) Edit_field = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) begin
        Clock_data     = $urandom;
        Calendar_data  = $urandom;
        Alarm_data     = $urandom;
        Countdown_data = $urandom;
      end
      step(1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
